// File: rtl/xilly_stream_reduce.sv
// Frame reducer between Xillybus write and read streams: header {opcode, N} plus N data words -> one result word.
// Optional count word after each result: define XILLY_STREAM_REDUCE_COUNT_WORD_EN.
module xilly_stream_reduce #(
    parameter int OUT_DEPTH = 16,
    parameter int MAX_LEN   = 4096
) (
    input  logic        bus_clk,
    input  logic        rst_n,
    input  logic        user_w_wren,
    output logic        user_w_full,
    input  logic [31:0] user_w_data,
    input  logic        user_w_open,
    input  logic        user_r_rden,
    output logic        user_r_empty,
    output logic [31:0] user_r_data,
    output logic        user_r_eof,
    input  logic        user_r_open,
    output logic [15:0] frame_cnt,
    output logic        err_flag
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int LW = $clog2(MAX_LEN + 1);
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
    localparam int WPF = 2;
`else
    localparam int WPF = 1;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    typedef struct packed {
        logic [15:0] opcode;
        logic [15:0] len;
    } hdr_t;

    state_t         state, state_n;
    hdr_t           hdr;
    logic           flush;
    logic           w_acc;
    logic           pop;
    logic           push;
    logic           last_push;
    logic [31:0]    push_data;
    logic [LW-1:0]  n_clamp;
    logic [AW:0]    occ;
    logic [AW:0]    free_slots;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [31:0]    mem [OUT_DEPTH];
    logic [31:0]    acc;
    logic [31:0]    acc_n;
    logic [31:0]    result;
    logic [LW-1:0]  remaining;
    logic [LW-1:0]  len_q;
    logic [1:0]     op_q;
    logic           bad_q;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
    logic           emit_idx;
`endif

    assign hdr          = hdr_t'(user_w_data);
    assign flush        = !user_w_open && !user_r_open;
    assign user_r_eof   = 1'b0;
    assign user_r_empty = (occ == '0);
    assign free_slots   = (AW+1)'(OUT_DEPTH) - occ;
    assign pop          = user_r_rden && !user_r_empty;
    assign w_acc        = user_w_wren && !user_w_full;
    assign n_clamp      = (hdr.len > 16'(MAX_LEN)) ? LW'(MAX_LEN) : hdr.len[LW-1:0];
    assign result       = bad_q ? 32'hFFFF_FFFF : acc;

    // Headroom for a whole frame's output is reserved before the header is taken,
    // so EMIT never has to stall on a full FIFO.
    always_comb begin
        user_w_full = 1'b0;
        case (state)
            IDLE:    user_w_full = (free_slots < (AW+1)'(WPF));
            ACCUM:   user_w_full = 1'b0;
            EMIT:    user_w_full = 1'b1;
            default: user_w_full = 1'b1;
        endcase
        if (flush)
            user_w_full = 1'b0;
        if (!rst_n)
            user_w_full = 1'b1;
    end

    always_comb begin
        case (op_q)
            2'd0:    acc_n = acc + user_w_data;
            2'd1:    acc_n = acc ^ user_w_data;
            2'd2:    acc_n = (user_w_data > acc) ? user_w_data : acc;
            default: acc_n = acc;
        endcase
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_data = '0;
        last_push = 1'b0;
        case (state)
            IDLE: begin
                if (w_acc)
                    state_n = (n_clamp == '0) ? EMIT : ACCUM;
            end
            ACCUM: begin
                if (w_acc && remaining == LW'(1))
                    state_n = EMIT;
            end
            EMIT: begin
                push = 1'b1;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
                push_data = emit_idx ? {16'h0, 16'(len_q)} : result;
                last_push = emit_idx;
`else
                push_data = result;
                last_push = 1'b1;
`endif
                if (last_push)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (flush)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            remaining   <= '0;
            len_q       <= '0;
            op_q        <= '0;
            bad_q       <= 1'b0;
            err_flag    <= 1'b0;
            frame_cnt   <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            user_r_data <= '0;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
            emit_idx    <= 1'b0;
`endif
        end else if (flush) begin
            acc         <= '0;
            remaining   <= '0;
            len_q       <= '0;
            op_q        <= '0;
            bad_q       <= 1'b0;
            err_flag    <= 1'b0;
            frame_cnt   <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            user_r_data <= '0;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
            emit_idx    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && w_acc) begin
                op_q      <= hdr.opcode[1:0];
                bad_q     <= (hdr.opcode > 16'd2);
                err_flag  <= err_flag | (hdr.opcode > 16'd2);
                acc       <= '0;
                remaining <= n_clamp;
                len_q     <= n_clamp;
            end
            if (state == ACCUM && w_acc) begin
                acc       <= acc_n;
                remaining <= remaining - LW'(1);
            end
            if (push && last_push)
                frame_cnt <= frame_cnt + 16'd1;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
            if (push)
                emit_idx <= !last_push;
`endif
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                user_r_data <= mem[rd_ptr];
            end
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge bus_clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_xilly_stream_reduce.sv
// Directed bench for xilly_stream_reduce: table of frames plus hand sequences for latency, clamp, flush, reset and backpressure.
module tb_xilly_stream_reduce;
    localparam int OUT_DEPTH = 16;
    localparam int MAX_LEN   = 8;
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
    localparam int WPF = 2;
`else
    localparam int WPF = 1;
`endif
    localparam int FIT = OUT_DEPTH / WPF;

    logic        bus_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        user_w_wren = 1'b0;
    logic        user_w_full;
    logic [31:0] user_w_data = '0;
    logic        user_w_open = 1'b1;
    logic        user_r_rden = 1'b0;
    logic        user_r_empty;
    logic [31:0] user_r_data;
    logic        user_r_eof;
    logic        user_r_open = 1'b1;
    logic [15:0] frame_cnt;
    logic        err_flag;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_rd = '0;

    always #5 bus_clk = ~bus_clk;

    xilly_stream_reduce #(.OUT_DEPTH(OUT_DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .bus_clk(bus_clk), .rst_n(rst_n),
        .user_w_wren(user_w_wren), .user_w_full(user_w_full),
        .user_w_data(user_w_data), .user_w_open(user_w_open),
        .user_r_rden(user_r_rden), .user_r_empty(user_r_empty),
        .user_r_data(user_r_data), .user_r_eof(user_r_eof),
        .user_r_open(user_r_open), .frame_cnt(frame_cnt), .err_flag(err_flag)
    );

    typedef struct {
        logic [31:0]       hdr;
        logic [3:0][31:0]  d;
        logic [31:0]       exp;
        logic              exp_err;
    } vec_t;

    function automatic vec_t mk(logic [31:0] h, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic [31:0] e, logic er);
        vec_t v;
        v.hdr = h; v.d = '0; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.exp = e; v.exp_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        int t = 0;
        @(negedge bus_clk);
        while (user_w_full && t < 200) begin
            @(negedge bus_clk);
            t++;
        end
        if (t >= 200) begin
            tests++; fails++;
            $display("FAIL wr_timeout: full stuck got 1 expected 0");
        end
        user_w_wren = 1'b1;
        user_w_data = d;
        @(negedge bus_clk);
        user_w_wren = 1'b0;
    endtask

    task automatic rd(output logic [31:0] d);
        int t = 0;
        @(negedge bus_clk);
        while (user_r_empty && t < 200) begin
            @(negedge bus_clk);
            t++;
        end
        if (t >= 200) begin
            tests++; fails++;
            $display("FAIL rd_timeout: empty stuck got 1 expected 0");
        end
        user_r_rden = 1'b1;
        @(negedge bus_clk);
        user_r_rden = 1'b0;
        d = user_r_data;
        last_rd = d;
    endtask

    task automatic rd_frame(input string nm, input logic [31:0] exp, input logic [15:0] n);
        logic [31:0] d;
        rd(d);
        chk({nm, "_result"}, d, exp);
`ifdef XILLY_STREAM_REDUCE_COUNT_WORD_EN
        rd(d);
        chk({nm, "_count"}, d, {16'h0, n});
`else
        if (n == 16'hFFFF) $display("unexpected length");
`endif
    endtask

    vec_t v[7];

    initial begin
        v[0] = mk(32'h0000_0003, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        v[1] = mk(32'h0001_0002, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 32'hFFFF_FFFF, 1'b0);
        v[2] = mk(32'h0002_0003, 32'h5, 32'h8000_0000, 32'h7, 32'h8000_0000, 1'b0);
        v[3] = mk(32'h0007_0001, 32'hAA, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
        v[4] = mk(32'h0000_0002, 32'h10, 32'h20, 32'h0, 32'h0000_0030, 1'b1);
        v[5] = mk(32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b1);
        v[6] = mk(32'h0002_0002, 32'h3, 32'h9, 32'h0, 32'h0000_0009, 1'b1);

        // reset state
        #12;
        chk("rst_full", {31'h0, user_w_full}, 32'h1);
        chk("rst_empty", {31'h0, user_r_empty}, 32'h1);
        chk("rst_data", user_r_data, 32'h0);
        chk("rst_fcnt", {16'h0, frame_cnt}, 32'h0);
        chk("rst_err", {31'h0, err_flag}, 32'h0);
        chk("rst_eof", {31'h0, user_r_eof}, 32'h0);
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(negedge bus_clk);
        chk("post_rst_full", {31'h0, user_w_full}, 32'h0);

        for (int i = 0; i < 7; i++) begin
            wr(v[i].hdr);
            for (int j = 0; j < int'(v[i].hdr[15:0]); j++)
                wr(v[i].d[j]);
            rd_frame($sformatf("vec%0d", i), v[i].exp, v[i].hdr[15:0]);
            chk($sformatf("vec%0d_fcnt", i), {16'h0, frame_cnt}, i + 1);
            chk($sformatf("vec%0d_err", i), {31'h0, err_flag}, {31'h0, v[i].exp_err});
            chk($sformatf("vec%0d_empty", i), {31'h0, user_r_empty}, 32'h1);
        end

        // latency: result visible only after the edge following the last data write
        wr(32'h0000_0001);
        user_w_wren = 1'b1;
        user_w_data = 32'h9;
        @(negedge bus_clk);
        user_w_wren = 1'b0;
        chk("lat_empty_T", {31'h0, user_r_empty}, 32'h1);
        @(negedge bus_clk);
        chk("lat_empty_T1", {31'h0, user_r_empty}, 32'h0);
        rd_frame("lat", 32'h9, 16'd1);

        // clamp: N=16 takes only MAX_LEN words, the next word is a new header
        wr(32'h0000_0010);
        for (int j = 0; j < MAX_LEN; j++) wr(32'h1);
        rd_frame("clamp", 32'd8, 16'd8);
        wr(32'h0001_0001);
        wr(32'h5);
        rd_frame("clamp_next", 32'h5, 16'd1);
        chk("clamp_fcnt", {16'h0, frame_cnt}, 32'd10);

        // flush mid-frame
        wr(32'h0000_0005); wr(32'h1); wr(32'h2);
        user_w_open = 1'b0; user_r_open = 1'b0;
        @(negedge bus_clk);
        @(negedge bus_clk);
        chk("flush_empty", {31'h0, user_r_empty}, 32'h1);
        chk("flush_fcnt", {16'h0, frame_cnt}, 32'h0);
        chk("flush_err", {31'h0, err_flag}, 32'h0);
        chk("flush_full", {31'h0, user_w_full}, 32'h0);
        user_w_open = 1'b1; user_r_open = 1'b1;
        wr(32'h0000_0002); wr(32'h4); wr(32'h5);
        rd_frame("after_flush", 32'h9, 16'd2);
        chk("after_flush_fcnt", {16'h0, frame_cnt}, 32'h1);

        // reset pulse mid-frame
        wr(32'h0000_0005); wr(32'h1); wr(32'h2);
        rst_n = 1'b0;
        #1;
        chk("rstp_full", {31'h0, user_w_full}, 32'h1);
        chk("rstp_empty", {31'h0, user_r_empty}, 32'h1);
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(negedge bus_clk);
        chk("rstp_full_rel", {31'h0, user_w_full}, 32'h0);
        chk("rstp_fcnt", {16'h0, frame_cnt}, 32'h0);
        wr(32'h0001_0002); wr(32'h3); wr(32'h6);
        rd_frame("after_rst", 32'h5, 16'd2);
        chk("after_rst_fcnt", {16'h0, frame_cnt}, 32'h1);

        // backpressure: fill the FIFO without reading
        for (int k = 0; k < FIT; k++) begin
            wr(32'h0000_0001);
            wr(32'd100 + k);
        end
        repeat (3) @(negedge bus_clk);
        chk("fill_full", {31'h0, user_w_full}, 32'h1);
        chk("fill_fcnt", {16'h0, frame_cnt}, 32'(1 + FIT));
        user_w_wren = 1'b1;
        user_w_data = 32'h0003_0000;
        @(negedge bus_clk);
        user_w_wren = 1'b0;
        repeat (2) @(negedge bus_clk);
        chk("ignored_wren_err", {31'h0, err_flag}, 32'h0);
        chk("ignored_wren_fcnt", {16'h0, frame_cnt}, 32'(1 + FIT));
        rd_frame("fill0", 32'd100, 16'd1);
        begin
            int k = 0;
            while (user_w_full && k < 2) begin
                @(negedge bus_clk);
                k++;
            end
        end
        chk("unfull", {31'h0, user_w_full}, 32'h0);
        wr(32'h0000_0001);
        wr(32'd100 + FIT);
        for (int k = 1; k <= FIT; k++)
            rd_frame($sformatf("fill%0d", k), 32'd100 + k, 16'd1);
        chk("fill_end_fcnt", {16'h0, frame_cnt}, 32'(2 + FIT));
        chk("fill_end_empty", {31'h0, user_r_empty}, 32'h1);

        // rden while empty leaves data alone
        @(negedge bus_clk);
        user_r_rden = 1'b1;
        @(negedge bus_clk);
        user_r_rden = 1'b0;
        @(negedge bus_clk);
        chk("rd_empty_hold", user_r_data, last_rd);
        chk("rd_empty_still", {31'h0, user_r_empty}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
